// File: rtl/scope_panel_ctrl.sv
`default_nettype none
// scope_panel_ctrl: debounced, single-button-arbitrated front panel driving scope display settings.
// Rev 1.0
module scope_panel_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int CUR_W      = 11,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int OFF_MAX    = 479,
  parameter int SHIFT_W    = 4,
  parameter int SAMP_W     = 6,
  parameter int DEB_CYC    = 8,
  parameter int REP_DELAY  = 40,
  parameter int REP_PERIOD = 5,
  parameter int Y1_INIT    = 25,
  parameter int Y2_INIT    = 100,
  parameter int X1_INIT    = 32,
  parameter int X2_INIT    = 90,
  parameter int OFF_INIT   = 30,
  parameter int OFF_STEP   = 170,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      buttonClock,
  input  logic                      reset_n,
  input  logic [3:0]                butt_n,
  input  logic [1:0]                mode,
  input  logic [1:0]                sel,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [1:0]                cur_en_in,
  input  logic [NUM_CH-1:0]         ch_en_in,
  output logic [CUR_W-1:0]          cursor_x1,
  output logic [CUR_W-1:0]          cursor_x2,
  output logic [CUR_W-1:0]          cursor_y1,
  output logic [CUR_W-1:0]          cursor_y2,
  output logic                      cursor_x_en,
  output logic                      cursor_y_en,
  output logic [NUM_CH-1:0]         wave_en,
  output logic [NUM_CH*CUR_W-1:0]   offset,
  output logic [NUM_CH*SHIFT_W-1:0] shift,
  output logic [NUM_CH*SAMP_W-1:0]  samp_adj,
  output logic [NUM_CH-1:0]         hold
);

  function automatic logic [NUM_CH*CUR_W-1:0] off_reset();
    logic [NUM_CH*CUR_W-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v = OFF_INIT + i * OFF_STEP;
      if (v > OFF_MAX) v = OFF_MAX;
      r[i*CUR_W +: CUR_W] = v[CUR_W-1:0];
    end
    return r;
  endfunction

  localparam int DEB_W   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RC_W    = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DEB_W-1:0]        DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [RC_W-1:0]         DLY_LAST = RC_W'(REP_DELAY - 1);
  localparam logic [RC_W-1:0]         PER_LAST = RC_W'(REP_PERIOD - 1);
  localparam logic [CUR_W-1:0]        XM       = CUR_W'(X_MAX);
  localparam logic [CUR_W-1:0]        YM       = CUR_W'(Y_MAX);
  localparam logic [CUR_W-1:0]        OM       = CUR_W'(OFF_MAX);
  localparam logic [CH_W:0]           NCH      = (CH_W + 1)'(NUM_CH);
  localparam logic [NUM_CH*CUR_W-1:0] OFF_RST  = off_reset();

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESS    = 3'd1;
  localparam logic [2:0] S_WAIT_DLY = 3'd2;
  localparam logic [2:0] S_REPEAT   = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  function automatic logic [CUR_W-1:0] sat_cur(input logic [CUR_W-1:0] v, input logic up,
                                               input logic [CUR_W-1:0] mx);
    if (up) return (v >= mx) ? mx : v + 1'b1;
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [SHIFT_W-1:0] sat_sh(input logic [SHIFT_W-1:0] v, input logic up);
    if (up) return (&v) ? v : v + 1'b1;
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [SAMP_W-1:0] sat_sa(input logic [SAMP_W-1:0] v, input logic up);
    if (up) return (&v) ? v : v + 1'b1;
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic [3:0] sync1_q, sync2_q, deb_lvl;

  always_ff @(posedge buttonClock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= butt_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounced level flips only after DEB_CYC consecutive samples disagree with it.
  for (genvar b = 0; b < 4; b++) begin : g_deb
    logic [DEB_W-1:0] cnt_q;
    logic             lvl_q;
    always_ff @(posedge buttonClock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        lvl_q <= 1'b1;
      end else if (sync2_q[b] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        cnt_q <= '0;
        lvl_q <= sync2_q[b];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign deb_lvl[b] = lvl_q;
  end

  logic [2:0]      state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [1:0]      act_q, act_d;
  logic            ev_q, ev_d;
  logic            rel, repeatable;

  assign rel        = deb_lvl[act_q];
  assign repeatable = (mode == 2'b00) || (mode == 2'b01 && sel == 2'b00);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    act_d   = act_q;
    ev_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!(&deb_lvl)) begin
          for (int i = 0; i < 4; i++) if (!deb_lvl[i]) act_d = i[1:0];
          ev_d    = 1'b1;
          state_d = S_PRESS;
        end
      end
      S_PRESS: begin
        rcnt_d = '0;
        if (rel)             state_d = S_IDLE;
        else if (repeatable) state_d = S_WAIT_DLY;
        else                 state_d = S_WAIT_REL;
      end
      S_WAIT_DLY: begin
        if (rel) state_d = S_IDLE;
        else if (rcnt_q == DLY_LAST) begin
          ev_d    = 1'b1;
          rcnt_d  = '0;
          state_d = S_REPEAT;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      S_REPEAT: begin
        if (rel) state_d = S_IDLE;
        else if (rcnt_q == PER_LAST) begin
          ev_d   = 1'b1;
          rcnt_d = '0;
        end else rcnt_d = rcnt_q + 1'b1;
      end
      S_WAIT_REL: if (rel) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  logic [CUR_W-1:0]          x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic                      cx_en_q, cx_en_d, cy_en_q, cy_en_d;
  logic [NUM_CH-1:0]         wave_en_q, wave_en_d, hold_q, hold_d;
  logic [NUM_CH*CUR_W-1:0]   off_q, off_d;
  logic [NUM_CH*SHIFT_W-1:0] shift_q, shift_d;
  logic [NUM_CH*SAMP_W-1:0]  samp_q, samp_d;
  logic                      up, is_a, ch_ok;

  // Button index encodes the action: bit 1 selects field A, bit 0 selects increment.
  assign up    = act_q[0];
  assign is_a  = act_q[1];
  assign ch_ok = {1'b0, ch_sel} < NCH;

  always_comb begin
    x1_d      = x1_q;
    x2_d      = x2_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    cx_en_d   = cx_en_q;
    cy_en_d   = cy_en_q;
    wave_en_d = wave_en_q;
    hold_d    = hold_q;
    off_d     = off_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    if (mode == 2'b00) begin
      cx_en_d = cur_en_in[0];
      cy_en_d = cur_en_in[1];
    end
    if (mode == 2'b01) wave_en_d = ch_en_in;
    if (ev_q && mode == 2'b00) begin
      case (sel)
        2'b00: if (is_a) y1_d = sat_cur(y1_q, up, YM); else y2_d = sat_cur(y2_q, up, YM);
        2'b01: if (is_a) x1_d = sat_cur(x1_q, up, XM); else x2_d = sat_cur(x2_q, up, XM);
        2'b10: begin
          if (up ? (y1_q < YM && y2_q < YM) : (y1_q != '0 && y2_q != '0)) begin
            y1_d = sat_cur(y1_q, up, YM);
            y2_d = sat_cur(y2_q, up, YM);
          end
        end
        default: begin
          if (up ? (x1_q < XM && x2_q < XM) : (x1_q != '0 && x2_q != '0)) begin
            x1_d = sat_cur(x1_q, up, XM);
            x2_d = sat_cur(x2_q, up, XM);
          end
        end
      endcase
    end
    if (ev_q && mode == 2'b01 && is_a && ch_ok) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_sel == i[CH_W-1:0]) begin
          case (sel)
            2'b00:   off_d[i*CUR_W +: CUR_W] = sat_cur(off_q[i*CUR_W +: CUR_W], up, OM);
            2'b01:   shift_d[i*SHIFT_W +: SHIFT_W] = sat_sh(shift_q[i*SHIFT_W +: SHIFT_W], up);
            2'b10:   hold_d[i] = up;
            default: samp_d[i*SAMP_W +: SAMP_W] = sat_sa(samp_q[i*SAMP_W +: SAMP_W], up);
          endcase
        end
      end
    end
  end

  always_ff @(posedge buttonClock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      act_q     <= '0;
      ev_q      <= 1'b0;
      x1_q      <= CUR_W'(X1_INIT);
      x2_q      <= CUR_W'(X2_INIT);
      y1_q      <= CUR_W'(Y1_INIT);
      y2_q      <= CUR_W'(Y2_INIT);
      cx_en_q   <= 1'b0;
      cy_en_q   <= 1'b0;
      wave_en_q <= '0;
      hold_q    <= '0;
      off_q     <= OFF_RST;
      shift_q   <= '0;
      samp_q    <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      act_q     <= act_d;
      ev_q      <= ev_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      cx_en_q   <= cx_en_d;
      cy_en_q   <= cy_en_d;
      wave_en_q <= wave_en_d;
      hold_q    <= hold_d;
      off_q     <= off_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
    end
  end

  assign cursor_x1   = x1_q;
  assign cursor_x2   = x2_q;
  assign cursor_y1   = y1_q;
  assign cursor_y2   = y2_q;
  assign cursor_x_en = cx_en_q;
  assign cursor_y_en = cy_en_q;
  assign wave_en     = wave_en_q;
  assign offset      = off_q;
  assign shift       = shift_q;
  assign samp_adj    = samp_q;
  assign hold        = hold_q;

endmodule
`default_nettype wire
